// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the PC, issues single-outstanding fetches to a
// variable-latency instruction memory and drives the IF/ID pipeline register.
module if_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            ifid_valid_o,
  output logic [XLEN-1:0] ifid_pc_o,
  output logic [XLEN-1:0] ifid_pc4_o,
  output logic [31:0]     ifid_instr_o
);

  typedef enum logic [1:0] {ISSUE, WAIT, BUF, DROP} state_t;

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] redir_tgt;
  logic [31:0]     buf_q;
  logic            accept;
  logic            release_buf;
  logic            deliver;
  logic            capture;
  logic [31:0]     dlv_instr;
  logic            unused_pc_lsbs;

  assign pc_inc         = pc_q + XLEN'(4);
  assign redir_tgt      = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign unused_pc_lsbs = ^redirect_pc_i[1:0];

  assign accept      = (state_q == WAIT) & imem_rvalid_i & ~redirect_i & ~stall_i;
  assign capture     = (state_q == WAIT) & imem_rvalid_i & ~redirect_i &  stall_i;
  assign release_buf = (state_q == BUF) & ~redirect_i & ~stall_i;
  assign deliver     = accept | release_buf;
  assign dlv_instr   = (state_q == BUF) ? buf_q : imem_rdata_i;

  // An accepted response immediately launches the next sequential fetch, so the
  // request is combinational on the response to sustain one instruction per cycle.
  assign imem_req_o  = rst_i & ((state_q == ISSUE) | accept);
  assign imem_addr_o = (state_q == ISSUE) ? pc_q : pc_inc;

  // Fetch control: PC and state
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ISSUE;
      pc_q    <= RESET_PC;
    end else begin
      case (state_q)
        ISSUE: begin
          if (redirect_i) begin
            pc_q    <= redir_tgt;
            state_q <= DROP;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (redirect_i) begin
            pc_q    <= redir_tgt;
            state_q <= imem_rvalid_i ? ISSUE : DROP;
          end else if (imem_rvalid_i) begin
            if (stall_i) state_q <= BUF;
            else         pc_q    <= pc_inc;
          end
        end
        BUF: begin
          if (redirect_i) begin
            pc_q    <= redir_tgt;
            state_q <= ISSUE;
          end else if (!stall_i) begin
            pc_q    <= pc_inc;
            state_q <= ISSUE;
          end
        end
        DROP: begin
          if (redirect_i)    pc_q    <= redir_tgt;
          if (imem_rvalid_i) state_q <= ISSUE;
        end
        default: state_q <= ISSUE;
      endcase
    end
  end

  // Skid buffer holds a response that arrived while decode was stalled
  always_ff @(posedge clk_i) begin
    if (capture) buf_q <= imem_rdata_i;
  end

  // IF/ID register: redirect bubble beats stall hold beats delivery
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ifid_valid_o <= 1'b0;
      ifid_pc_o    <= '0;
      ifid_pc4_o   <= '0;
      ifid_instr_o <= NOP_INSTR;
    end else if (redirect_i) begin
      ifid_valid_o <= 1'b0;
      ifid_instr_o <= NOP_INSTR;
    end else if (!stall_i) begin
      if (deliver) begin
        ifid_valid_o <= 1'b1;
        ifid_pc_o    <= pc_q;
        ifid_pc4_o   <= pc_inc;
        ifid_instr_o <= dlv_instr;
      end else begin
        ifid_valid_o <= 1'b0;
        ifid_instr_o <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboarded bench for if_stage: a latency-programmable memory model answers
// fetches, and every instruction entering IF/ID is popped from an expected queue.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'hDEAD_BEEF;
  logic        ifid_valid_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_pc4_o;
  logic [31:0] ifid_instr_o;

  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;
  int tick = 0;
  int rel_tick = 0;
  int lat = 1;

  logic [31:0] sb_q[$];
  logic [31:0] exp_pc;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          remain = 0;
  logic        stall_prev = 1'b0;

  if_stage dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .ifid_valid_o  (ifid_valid_o),
    .ifid_pc_o     (ifid_pc_o),
    .ifid_pc4_o    (ifid_pc4_o),
    .ifid_instr_o  (ifid_instr_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A00_0003;
  endfunction

  function automatic int cur_cyc();
    return tick - rel_tick + 1;
  endfunction

  always @(posedge clk) begin
    tick++;
    stall_prev = stall;
  end

  // Memory model: one response exactly lat cycles after each request
  always @(posedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      n_cmp++;
      if ((rvalid && !pend) || (imem_req_o && pend && !rvalid)) begin
        n_err++;
        $display("FAIL protocol: rvalid=%0b req=%0b outstanding=%0b", rvalid, imem_req_o, pend);
      end
      if (rvalid) pend = 1'b0;
      if (imem_req_o) begin
        pend      = 1'b1;
        pend_addr = imem_addr_o;
        remain    = lat;
      end
    end
  end

  always @(negedge clk) begin
    if (pend && rst_n) begin
      remain--;
      if (remain == 0) begin
        rvalid = 1'b1;
        rdata  = instr_of(pend_addr);
      end else begin
        rvalid = 1'b0;
        rdata  = 32'hDEAD_BEEF;
      end
    end else begin
      rvalid = 1'b0;
      rdata  = 32'hDEAD_BEEF;
    end
  end

  // Scoreboard: a valid IF/ID not held by a stall is a newly loaded instruction
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (!ifid_valid_o) begin
        n_cmp++;
        if (ifid_instr_o !== NOP) begin
          n_err++;
          $display("FAIL bubble_instr: got %h expected %h", ifid_instr_o, NOP);
        end
      end else if (!stall_prev) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: got pc %h, expected no delivery", ifid_pc_o);
        end else begin
          exp_pc = sb_q.pop_front();
          n_pop++;
          if ({ifid_pc_o, ifid_pc4_o, ifid_instr_o} !== {exp_pc, exp_pc + 32'd4, instr_of(exp_pc)}) begin
            n_err++;
            $display("FAIL sb_delivery: got pc/pc4/instr %h/%h/%h expected %h/%h/%h",
                     ifid_pc_o, ifid_pc4_o, ifid_instr_o, exp_pc, exp_pc + 32'd4, instr_of(exp_pc));
          end
        end
      end
    end
  end

  task automatic goto(input int n);
    int guard = 0;
    while (cur_cyc() < n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cur_cyc() != n) begin
      n_cmp++;
      n_err++;
      $display("FAIL goto: got cycle %0d expected %0d", cur_cyc(), n);
    end
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(start + 32'(4 * i));
  endtask

  task automatic do_reset(input int latency);
    @(negedge clk);
    rst_n    = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    repeat (2) @(negedge clk);
    sb_q.delete();
    lat      = latency;
    rel_tick = tick;
    rst_n    = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({imem_req_o, ifid_valid_o} !== 2'b00) begin
      n_err++; $display("FAIL reset_req_valid: got %b expected 00", {imem_req_o, ifid_valid_o});
    end
    n_cmp++;
    if (ifid_pc_o !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h expected 0", ifid_pc_o); end
    n_cmp++;
    if (ifid_pc4_o !== 32'h0) begin n_err++; $display("FAIL reset_pc4: got %h expected 0", ifid_pc4_o); end
    n_cmp++;
    if (ifid_instr_o !== NOP) begin n_err++; $display("FAIL reset_instr: got %h expected %h", ifid_instr_o, NOP); end
  endtask

  task automatic test_lat1();
    int p0;
    do_reset(1);
    push_seq(32'h0, 32);
    p0 = n_pop;
    #1;
    n_cmp++;
    if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL lat1_first_req: got %b/%h expected 1/00000000", imem_req_o, imem_addr_o);
    end
    goto(2); #1;
    n_cmp++;
    if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h4}) begin
      n_err++; $display("FAIL lat1_second_req: got %b/%h expected 1/00000004", imem_req_o, imem_addr_o);
    end
    for (int c = 3; c <= 6; c++) begin
      goto(c); #1;
      n_cmp++;
      if ({ifid_valid_o, ifid_pc_o, ifid_pc4_o} !== {1'b1, 32'(4 * (c - 3)), 32'(4 * (c - 2))}) begin
        n_err++; $display("FAIL lat1_stream c%0d: got %b/%h/%h expected 1/%h/%h", c,
                          ifid_valid_o, ifid_pc_o, ifid_pc4_o, 32'(4 * (c - 3)), 32'(4 * (c - 2)));
      end
    end
    goto(13);
    n_cmp++;
    if (n_pop - p0 !== 10) begin n_err++; $display("FAIL lat1_count: got %0d expected 10", n_pop - p0); end
  endtask

  task automatic test_lat3();
    do_reset(3);
    push_seq(32'h0, 16);
    for (int c = 1; c <= 14; c++) begin
      goto(c); #1;
      n_cmp++;
      if (imem_req_o !== (c % 3 == 1)) begin
        n_err++; $display("FAIL lat3_req c%0d: got %b expected %b", c, imem_req_o, (c % 3 == 1));
      end else if (imem_req_o && imem_addr_o !== 32'((c - 1) / 3 * 4)) begin
        n_err++; $display("FAIL lat3_addr c%0d: got %h expected %h", c, imem_addr_o, 32'((c - 1) / 3 * 4));
      end
      n_cmp++;
      if (ifid_valid_o !== (c >= 5 && (c - 5) % 3 == 0)) begin
        n_err++; $display("FAIL lat3_valid c%0d: got %b expected %b", c, ifid_valid_o, (c >= 5 && (c - 5) % 3 == 0));
      end
    end
  endtask

  task automatic test_stall();
    do_reset(1);
    push_seq(32'h0, 32);
    goto(6); stall = 1'b1; #1;
    n_cmp++;
    if ({imem_req_o, ifid_valid_o, ifid_pc_o} !== {2'b01, 32'hC}) begin
      n_err++; $display("FAIL stall_c6: got req %b valid %b pc %h expected 0/1/0000000c", imem_req_o, ifid_valid_o, ifid_pc_o);
    end
    goto(7); #1;
    n_cmp++;
    if ({imem_req_o, ifid_pc_o} !== {1'b0, 32'hC}) begin
      n_err++; $display("FAIL stall_c7: got req %b pc %h expected 0/0000000c", imem_req_o, ifid_pc_o);
    end
    goto(8); stall = 1'b0; #1;
    n_cmp++;
    if ({imem_req_o, ifid_pc_o} !== {1'b0, 32'hC}) begin
      n_err++; $display("FAIL stall_c8: got req %b pc %h expected 0/0000000c", imem_req_o, ifid_pc_o);
    end
    goto(9); #1;
    n_cmp++;
    if ({ifid_valid_o, ifid_pc_o, ifid_instr_o} !== {1'b1, 32'h10, instr_of(32'h10)}) begin
      n_err++; $display("FAIL stall_release: got %b/%h/%h expected 1/00000010/%h", ifid_valid_o, ifid_pc_o, ifid_instr_o, instr_of(32'h10));
    end
    n_cmp++;
    if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h14}) begin
      n_err++; $display("FAIL stall_next_req: got %b/%h expected 1/00000014", imem_req_o, imem_addr_o);
    end
    goto(11); #1;
    n_cmp++;
    if ({ifid_valid_o, ifid_pc_o} !== {1'b1, 32'h14}) begin
      n_err++; $display("FAIL stall_after: got %b/%h expected 1/00000014", ifid_valid_o, ifid_pc_o);
    end
  endtask

  task automatic test_redirect();
    int p0;
    do_reset(3);
    push_seq(32'h0, 5);
    push_seq(32'h40, 16);
    p0 = n_pop;
    goto(17); redirect = 1'b1; redirect_pc = 32'h43; #1;
    n_cmp++;
    if ({imem_req_o, ifid_valid_o, ifid_pc_o} !== {2'b01, 32'h10}) begin
      n_err++; $display("FAIL redir_c17: got req %b valid %b pc %h expected 0/1/00000010", imem_req_o, ifid_valid_o, ifid_pc_o);
    end
    goto(18); redirect = 1'b0; #1;
    n_cmp++;
    if ({imem_req_o, ifid_valid_o, ifid_instr_o} !== {2'b00, NOP}) begin
      n_err++; $display("FAIL redir_bubble: got req %b valid %b instr %h expected 0/0/%h", imem_req_o, ifid_valid_o, ifid_instr_o, NOP);
    end
    goto(19); #1;
    n_cmp++;
    if (imem_req_o !== 1'b0) begin n_err++; $display("FAIL redir_drop_req: got %b expected 0", imem_req_o); end
    goto(20); #1;
    n_cmp++;
    if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h40}) begin
      n_err++; $display("FAIL redir_target_req: got %b/%h expected 1/00000040", imem_req_o, imem_addr_o);
    end
    goto(24); #1;
    n_cmp++;
    if ({ifid_valid_o, ifid_pc_o} !== {1'b1, 32'h40}) begin
      n_err++; $display("FAIL redir_target_ifid: got %b/%h expected 1/00000040", ifid_valid_o, ifid_pc_o);
    end
    goto(28);
    n_cmp++;
    if (n_pop - p0 !== 7) begin n_err++; $display("FAIL redir_count: got %0d expected 7", n_pop - p0); end
  endtask

  task automatic test_redirect_stall();
    int p0;
    do_reset(1);
    push_seq(32'h0, 4);
    push_seq(32'h80, 16);
    p0 = n_pop;
    goto(6); redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h80; #1;
    n_cmp++;
    if (imem_req_o !== 1'b0) begin n_err++; $display("FAIL rs_req_c6: got %b expected 0", imem_req_o); end
    goto(7); redirect = 1'b0; stall = 1'b0; #1;
    n_cmp++;
    if ({ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o} !== {1'b0, 32'hC, 32'h10, NOP}) begin
      n_err++; $display("FAIL rs_bubble: got %b/%h/%h/%h expected 0/0000000c/00000010/%h",
                        ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o, NOP);
    end
    n_cmp++;
    if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h80}) begin
      n_err++; $display("FAIL rs_target_req: got %b/%h expected 1/00000080", imem_req_o, imem_addr_o);
    end
    goto(9); #1;
    n_cmp++;
    if ({ifid_valid_o, ifid_pc_o} !== {1'b1, 32'h80}) begin
      n_err++; $display("FAIL rs_target_ifid: got %b/%h expected 1/00000080", ifid_valid_o, ifid_pc_o);
    end
    goto(10);
    n_cmp++;
    if (n_pop - p0 !== 5) begin n_err++; $display("FAIL rs_count: got %0d expected 5", n_pop - p0); end
  endtask

  task automatic test_wrap();
    do_reset(1);
    sb_q.push_back(32'h0);
    sb_q.push_back(32'hFFFF_FFFC);
    push_seq(32'h0, 16);
    goto(3); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
    goto(4); redirect = 1'b0; #1;
    n_cmp++;
    if ({imem_req_o, imem_addr_o, ifid_valid_o} !== {1'b1, 32'hFFFF_FFFC, 1'b0}) begin
      n_err++; $display("FAIL wrap_req: got %b/%h valid %b expected 1/fffffffc valid 0", imem_req_o, imem_addr_o, ifid_valid_o);
    end
    goto(5); #1;
    n_cmp++;
    if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL wrap_next_req: got %b/%h expected 1/00000000", imem_req_o, imem_addr_o);
    end
    goto(6); #1;
    n_cmp++;
    if ({ifid_pc_o, ifid_pc4_o} !== {32'hFFFF_FFFC, 32'h0}) begin
      n_err++; $display("FAIL wrap_pc4: got %h/%h expected fffffffc/00000000", ifid_pc_o, ifid_pc4_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(3);
    push_seq(32'h0, 16);
    goto(26); #1;
    n_cmp++;
    if ({imem_req_o, ifid_valid_o, ifid_pc_o} !== {2'b01, 32'h1C}) begin
      n_err++; $display("FAIL rmid_pre: got req %b valid %b pc %h expected 0/1/0000001c", imem_req_o, ifid_valid_o, ifid_pc_o);
    end
    #2; rst_n = 1'b0; #1;
    n_cmp++;
    if ({imem_req_o, ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o} !== {2'b00, 32'h0, 32'h0, NOP}) begin
      n_err++; $display("FAIL rmid_async: got %b/%b/%h/%h/%h expected 0/0/00000000/00000000/%h",
                        imem_req_o, ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o, NOP);
    end
    do_reset(3);
    push_seq(32'h0, 16);
    #1;
    n_cmp++;
    if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL rmid_restart_req: got %b/%h expected 1/00000000", imem_req_o, imem_addr_o);
    end
    goto(5); #1;
    n_cmp++;
    if ({ifid_valid_o, ifid_pc_o} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL rmid_restart_ifid: got %b/%h expected 1/00000000", ifid_valid_o, ifid_pc_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lat1();
    test_lat3();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_reset_mid();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline. Holds the PC and issues fetches to a variable-latency instruction memory.
- Applies branch redirects and load-use stalls, and drives the IF/ID pipeline register that the decode stage consumes.
- Replaces the free-running PC/adder/IF-ID path with a handshaked front end. Allows at most one outstanding fetch.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h00000000, first fetch address after reset.
- NOP_INSTR, 32'h00000013, encoding placed in IF/ID for bubbles (addi x0,x0,0).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- stall_i  input  1  hazard unit: hold PC and IF/ID (load-use).
- redirect_i  input  1  taken branch/jump resolved downstream: refetch from redirect_pc_i and flush IF/ID.
- redirect_pc_i  input  XLEN  redirect target; bits [1:0] ignored (forced 0).
- imem_req_o  output  1  one-cycle fetch request pulse.
- imem_addr_o  output  XLEN  fetch address, valid while imem_req_o=1.
- imem_rvalid_i  input  1  fetch response valid; exactly one per request, in order, at least 1 cycle after the request.
- imem_rdata_i  input  32  fetched instruction, valid with imem_rvalid_i.
- ifid_valid_o  output  1  IF/ID holds a real instruction.
- ifid_pc_o  output  XLEN  PC of the IF/ID instruction.
- ifid_pc4_o  output  XLEN  ifid_pc_o+4, used for the JAL/JALR link value.
- ifid_instr_o  output  32  instruction in IF/ID; NOP_INSTR when invalid.

Behaviour:
- Reset (rst_i=0, async):
  - pc_q=RESET_PC, state=ISSUE.
  - imem_req_o=0 (forced while in reset).
  - ifid_valid_o=0, ifid_pc_o=0, ifid_pc4_o=0, ifid_instr_o=NOP_INSTR.
  - The memory discards any in-flight fetch on reset.
- States: ISSUE, WAIT, BUF, DROP. pc_q is the address of the instruction currently being fetched or buffered.
- ISSUE:
  - imem_req_o=1, imem_addr_o=pc_q; next state WAIT.
  - redirect_i in ISSUE: the request still goes out; pc_q<=redirect_pc_i; next state DROP.
- WAIT, imem_rvalid_i=0:
  - No request.
  - redirect_i: pc_q<=target; next state DROP.
- WAIT, imem_rvalid_i=1, redirect_i=0, stall_i=0 (accept):
  - IF/ID<={1, pc_q, pc_q+4, imem_rdata_i}; pc_q<=pc_q+4.
  - In the same cycle, imem_req_o=1 with imem_addr_o=pc_q+4; stay in WAIT.
  - Sustains 1 instr/cycle at memory latency 1.
- WAIT, imem_rvalid_i=1, stall_i=1, redirect_i=0:
  - Capture rdata into a 32-bit skid buffer; IF/ID holds; next state BUF.
- WAIT, imem_rvalid_i=1, redirect_i=1:
  - Discard the response; pc_q<=target; next state ISSUE.
- BUF:
  - No request.
  - stall_i=1: hold everything.
  - stall_i=0: IF/ID<={1, pc_q, pc_q+4, buffer}; pc_q<=pc_q+4; next state ISSUE.
  - redirect_i: discard the buffer; pc_q<=target; next state ISSUE.
- DROP:
  - No request; wait for the stale response.
  - On imem_rvalid_i: discard it; next state ISSUE.
  - A further redirect_i in DROP only updates pc_q.
- IF/ID update rules, in priority order:
  1. redirect_i=1: bubble (valid=0, instr=NOP_INSTR, pc fields hold). Overrides stall_i.
  2. Otherwise stall_i=1: hold all IF/ID fields.
  3. Otherwise, an instruction is delivered this cycle (accept in WAIT, release in BUF): load it.
  4. Otherwise: bubble.
- Arithmetic:
  - pc+4 wraps modulo 2^XLEN with no flag.
  - The PC is always word-aligned.
- Every response is either delivered to IF/ID exactly once or discarded; none is lost or duplicated.
- imem_rvalid_i in ISSUE, or with no outstanding request, is a protocol error. The bench asserts it never happens.

Test Plan:
- Reset release, memory latency 1, no stalls -> first request addr 0 in cycle 1. IF/ID pc 0,4,8,12 on consecutive cycles from cycle 3; ifid_pc4_o=pc+4.
- Memory latency 3 -> one request per instruction; ifid_valid_o high 1 cycle in every 3, with bubbles (NOP_INSTR) between.
- stall_i high 2 cycles while the response for pc 0x10 arrives -> state BUF. IF/ID holds the previous instruction; 0x10 enters IF/ID the cycle after stall_i falls. No extra request during the stall.
- redirect_i to 0x40 while the fetch of 0x14 is outstanding (latency 3) -> IF/ID bubble. The 0x14 response is dropped; the next request is addr 0x40; 0x40 reaches IF/ID.
- redirect_i and stall_i together in the same cycle as imem_rvalid_i -> redirect wins. IF/ID bubble, response discarded, next request at the target.
- rst_i pulled low mid-WAIT at pc 0x20 -> all outputs immediately take reset values. After release, the first request is RESET_PC.
